// File: rtl/interrupt_pkg.sv
// Interrupt controller types, vector constants and vector helper.
package interrupt_pkg;
  localparam int NUM_IRQ   = 5;
  localparam int IRQ_IDX_W = $clog2(NUM_IRQ);

  localparam logic [15:0] IRQ_VECTOR_BASE   = 16'h0040;
  localparam int          IRQ_VECTOR_STRIDE = 8;

  typedef enum logic [IRQ_IDX_W-1:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_id_t;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_ACKED,
    IC_VECTOR
  } ic_state_t;

  function automatic logic [15:0] irq_vec(
    input logic [IRQ_IDX_W-1:0] idx
  );
    return IRQ_VECTOR_BASE
         + 16'(idx) * 16'(IRQ_VECTOR_STRIDE);
  endfunction
endpackage

// File: rtl/mmu_addresses_pkg.sv
// MMU bus address map for memory-mapped peripheral registers.
package mmu_addresses_pkg;
  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;
endpackage

// File: rtl/interrupt_controller_if.sv
// MMU bus seen by a memory-mapped peripheral.
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        read_en;
  logic        write_en;

  modport master (
    output addr, wdata, read_en, write_en,
    input  rdata
  );

  modport slave (
    input  addr, wdata, read_en, write_en,
    output rdata
  );

  modport Peripheral_side (
    input  addr, wdata, read_en, write_en,
    output rdata
  );
endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// Lowest-index-wins priority encoder for pending interrupts.
module irq_priority_encoder #(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/interrupt_controller.sv
// IF/IE interrupt controller with CPU dispatch handshake.
// Define IRQ_CANCEL_EN to resolve the vector from live IE&IF at resolve.
module interrupt_controller
  import interrupt_pkg::*;
  import mmu_addresses_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  Bus_if.Peripheral_side bus,
  input  logic        vblank_req,
  input  logic        stat_req,
  input  logic        timer_req,
  input  logic        serial_req,
  input  logic        joypad_req,
  output logic        irq_pending,
  input  logic        cpu_ack,
  input  logic        cpu_resolve,
  output logic [15:0] irq_vector,
  output logic        vector_valid
);
  logic [NUM_IRQ-1:0]   if_q, if_d, if_base;
  logic [NUM_IRQ-1:0]   req, pend, clr_mask;
  logic [7:0]           ie_q;
  logic                 enc_valid, res_valid;
  logic [IRQ_IDX_W-1:0] enc_idx, res_idx;
  logic                 wr_if, wr_ie;
  logic                 do_ack, do_resolve;
  ic_state_t            state, state_d;

  assign req = {joypad_req, serial_req, timer_req,
                stat_req, vblank_req};
  assign pend        = ie_q[NUM_IRQ-1:0] & if_q;
  assign irq_pending = |pend;

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IRQ_IDX_W)
  ) u_enc (
    .req   (pend),
    .valid (enc_valid),
    .index (enc_idx)
  );

  assign wr_if = bus.write_en && (bus.addr == IF_ADDR);
  assign wr_ie = bus.write_en && (bus.addr == IE_ADDR);

  always_comb begin
    bus.rdata = 8'hFF;
    unique case (1'b1)
      (bus.addr == IF_ADDR): bus.rdata = {3'b111, if_q};
      (bus.addr == IE_ADDR): bus.rdata = ie_q;
      default:               bus.rdata = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state;
    do_ack     = 1'b0;
    do_resolve = 1'b0;
    unique case (state)
      IC_IDLE: begin
        if (cpu_ack) begin
          state_d = IC_ACKED;
          do_ack  = 1'b1;
        end
      end
      IC_ACKED: begin
        if (cpu_resolve) begin
          state_d    = IC_VECTOR;
          do_resolve = 1'b1;
        end
      end
      IC_VECTOR: state_d = IC_IDLE;
      default:   state_d = IC_IDLE;
    endcase
  end

`ifdef IRQ_CANCEL_EN
  assign res_valid = enc_valid;
  assign res_idx   = enc_idx;

  logic unused_ack;
  assign unused_ack = do_ack;
`else
  logic                 ack_valid_q;
  logic [IRQ_IDX_W-1:0] ack_idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_valid_q <= 1'b0;
      ack_idx_q   <= '0;
    end else if (do_ack) begin
      ack_valid_q <= enc_valid;
      ack_idx_q   <= enc_idx;
    end
  end

  assign res_valid = ack_valid_q;
  assign res_idx   = ack_idx_q;
`endif

  // Bus write first, then dispatch clear, then new requests win.
  assign clr_mask = (do_resolve && res_valid)
                  ? (NUM_IRQ'(1) << res_idx) : '0;
  assign if_base  = wr_if ? bus.wdata[NUM_IRQ-1:0] : if_q;
  assign if_d     = (if_base & ~clr_mask) | req;

  assign vector_valid = (state == IC_VECTOR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q       <= '0;
      ie_q       <= 8'h00;
      state      <= IC_IDLE;
      irq_vector <= 16'h0000;
    end else begin
      if_q  <= if_d;
      state <= state_d;
      if (wr_ie) ie_q <= bus.wdata;
      if (do_resolve)
        irq_vector <= res_valid ? irq_vec(res_idx)
                                : 16'h0000;
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vblank_req = 0, stat_req = 0;
  logic        timer_req = 0, serial_req = 0;
  logic        joypad_req = 0;
  logic        cpu_ack = 0, cpu_resolve = 0;
  logic        irq_pending, vector_valid;
  logic [15:0] irq_vector;
  int checks = 0;
  int failures = 0;

  Bus_if bus ();

  interrupt_controller dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .vblank_req   (vblank_req),
    .stat_req     (stat_req),
    .timer_req    (timer_req),
    .serial_req   (serial_req),
    .joypad_req   (joypad_req),
    .irq_pending  (irq_pending),
    .cpu_ack      (cpu_ack),
    .cpu_resolve  (cpu_resolve),
    .irq_vector   (irq_vector),
    .vector_valid (vector_valid)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [15:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a,
                    output logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.read_en = 1'b1;
    #1 d = bus.rdata;
    bus.read_en = 1'b0;
  endtask

  // ack, resolve, then sample the two cycles after resolve
  task automatic dispatch(output logic v1,
                          output logic [15:0] vec,
                          output logic v2);
    @(negedge clk); cpu_ack = 1'b1;
    @(negedge clk); cpu_ack = 1'b0; cpu_resolve = 1'b1;
    @(negedge clk); cpu_resolve = 1'b0;
    v1 = vector_valid; vec = irq_vector;
    @(negedge clk); v2 = vector_valid;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1;
    bus.addr = 16'h0000; bus.wdata = 8'h00;
    bus.read_en = 1'b0; bus.write_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(16'hFF0F, d);
    checks++;
    if (d !== 8'hE0) begin failures++;
      $display("FAIL reset_if got=%h exp=e0", d); end
    rd(16'hFFFF, d);
    checks++;
    if (d !== 8'h00) begin failures++;
      $display("FAIL reset_ie got=%h exp=00", d); end
    checks++;
    if (vector_valid !== 1'b0) begin failures++;
      $display("FAIL reset_vv got=%b exp=0", vector_valid); end
    checks++;
    if (irq_vector !== 16'h0000) begin failures++;
      $display("FAIL reset_vec got=%h exp=0000", irq_vector); end
    checks++;
    if (irq_pending !== 1'b0) begin failures++;
      $display("FAIL reset_pend got=%b exp=0", irq_pending); end
  endtask

  task automatic test_timer_req;
    logic [7:0] d;
    wr(16'hFFFF, 8'h04);
    @(negedge clk); timer_req = 1'b1;
    @(negedge clk); timer_req = 1'b0;
    rd(16'hFF0F, d);
    checks++;
    if (d !== 8'hE4) begin failures++;
      $display("FAIL timer_if got=%h exp=e4", d); end
    checks++;
    if (irq_pending !== 1'b1) begin failures++;
      $display("FAIL timer_pend got=%b exp=1", irq_pending); end
  endtask

  task automatic test_priority;
    logic v1, v2;
    logic [15:0] vec;
    logic [7:0] d;
    logic [15:0] exp_vec [3] = '{16'h0040, 16'h0048, 16'h0050};
    logic [7:0]  exp_if  [3] = '{8'hFE, 8'hFC, 8'hF8};
    wr(16'hFF0F, 8'h1F);
    wr(16'hFFFF, 8'h1F);
    for (int i = 0; i < 3; i++) begin
      dispatch(v1, vec, v2);
      rd(16'hFF0F, d);
      checks++;
      if (v1 !== 1'b1 || v2 !== 1'b0) begin failures++;
        $display("FAIL prio_vv%0d got=%b%b exp=10", i, v1, v2); end
      checks++;
      if (vec !== exp_vec[i]) begin failures++;
        $display("FAIL prio_vec%0d got=%h exp=%h",
                 i, vec, exp_vec[i]); end
      checks++;
      if (d !== exp_if[i]) begin failures++;
        $display("FAIL prio_if%0d got=%h exp=%h",
                 i, d, exp_if[i]); end
    end
    // IE masks the higher-priority bits
    wr(16'hFF0F, 8'h1F);
    wr(16'hFFFF, 8'h18);
    dispatch(v1, vec, v2);
    rd(16'hFF0F, d);
    checks++;
    if (vec !== 16'h0058) begin failures++;
      $display("FAIL mask_vec got=%h exp=0058", vec); end
    checks++;
    if (d !== 8'hF7) begin failures++;
      $display("FAIL mask_if got=%h exp=f7", d); end
  endtask

  task automatic test_write_vs_req;
    logic [7:0] d;
    @(negedge clk);
    bus.addr = 16'hFF0F; bus.wdata = 8'h00;
    bus.write_en = 1'b1; timer_req = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0; timer_req = 1'b0;
    rd(16'hFF0F, d);
    checks++;
    if (d !== 8'hE4) begin failures++;
      $display("FAIL wr_req_if got=%h exp=e4", d); end
  endtask

  task automatic test_no_source;
    logic v1, v2;
    logic [15:0] vec;
    logic [7:0] d;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h00);
    dispatch(v1, vec, v2);
    rd(16'hFF0F, d);
    checks++;
    if (v1 !== 1'b1 || vec !== 16'h0000) begin failures++;
      $display("FAIL nosrc got=%b/%h exp=1/0000", v1, vec); end
    checks++;
    if (d !== 8'hE0) begin failures++;
      $display("FAIL nosrc_if got=%h exp=e0", d); end
  endtask

  task automatic test_cancel;
    logic v1;
    logic [15:0] vec;
    logic [7:0] d;
    logic [15:0] exp_vec;
    logic [7:0]  exp_if;
`ifdef IRQ_CANCEL_EN
    exp_vec = 16'h0000; exp_if = 8'hE4;
`else
    exp_vec = 16'h0050; exp_if = 8'hE0;
`endif
    wr(16'hFFFF, 8'h04);
    wr(16'hFF0F, 8'h04);
    @(negedge clk); cpu_ack = 1'b1;
    @(negedge clk); cpu_ack = 1'b0;
    // extra ack while ACKED must be ignored
    cpu_ack = 1'b1;
    @(negedge clk); cpu_ack = 1'b0;
    wr(16'hFFFF, 8'h00);
    checks++;
    if (irq_pending !== 1'b0) begin failures++;
      $display("FAIL cancel_pend got=%b exp=0", irq_pending); end
    @(negedge clk); cpu_resolve = 1'b1;
    @(negedge clk); cpu_resolve = 1'b0;
    v1 = vector_valid; vec = irq_vector;
    rd(16'hFF0F, d);
    checks++;
    if (v1 !== 1'b1) begin failures++;
      $display("FAIL cancel_vv got=%b exp=1", v1); end
    checks++;
    if (vec !== exp_vec) begin failures++;
      $display("FAIL cancel_vec got=%h exp=%h", vec, exp_vec); end
    checks++;
    if (d !== exp_if) begin failures++;
      $display("FAIL cancel_if got=%h exp=%h", d, exp_if); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int pulses = 0;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h04);
    @(negedge clk); cpu_ack = 1'b1;
    @(negedge clk); cpu_ack = 1'b0;
    reset = 1'b1;
    #1 if (vector_valid) pulses++;
    @(negedge clk); reset = 1'b0;
    // resolve in IDLE is ignored
    cpu_resolve = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cpu_resolve = 1'b0;
      if (vector_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++;
      $display("FAIL rst_mid_vv got=%0d exp=0", pulses); end
    rd(16'hFF0F, d);
    checks++;
    if (d !== 8'hE0) begin failures++;
      $display("FAIL rst_mid_if got=%h exp=e0", d); end
    rd(16'hFFFF, d);
    checks++;
    if (d !== 8'h00) begin failures++;
      $display("FAIL rst_mid_ie got=%h exp=00", d); end
  endtask

  task automatic test_unmapped;
    logic [7:0] d;
    int bad = 0;
    for (int a = 16'hFF05; a <= 16'hFF10; a++) begin
      if (a != 16'hFF0F) begin
        rd(16'(a), d);
        if (d !== 8'hFF) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin failures++;
      $display("FAIL unmapped got=%0d bad exp=0", bad); end
    wr(16'hFFFF, 8'hFF);
    rd(16'hFFFF, d);
    checks++;
    if (d !== 8'hFF) begin failures++;
      $display("FAIL ie_ff got=%h exp=ff", d); end
  endtask

  initial begin
    test_reset;
    test_timer_req;
    test_priority;
    test_write_vs_req;
    test_no_source;
    test_cancel;
    test_reset_mid;
    test_unmapped;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
